// File: rtl/pci_initiator_ctrl_if.sv
// pci_initiator_ctrl_if: PCI master-side control pins shared by the initiator and the bus/target side.
interface pci_initiator_ctrl_if;
  logic REQ;
  logic GNT;
  logic FRAME_in;
  logic IRDY_in;
  logic TRDY;
  logic DEVSEL;
  logic STOP;
  logic FRAME;
  logic IRDY;
  logic ad_oe;
  logic addr_phase;
  logic xfer;
  modport master (
    output REQ, FRAME, IRDY, ad_oe, addr_phase, xfer,
    input  GNT, FRAME_in, IRDY_in, TRDY, DEVSEL, STOP
  );
  modport slave (
    input  REQ, FRAME, IRDY, ad_oe, addr_phase, xfer,
    output GNT, FRAME_in, IRDY_in, TRDY, DEVSEL, STOP
  );
endinterface

// File: rtl/pci_initiator_ctrl.sv
// pci_initiator_ctrl: PCI master transaction sequencer (request, address phase, FRAME/IRDY data handshake, termination).
module pci_initiator_ctrl #(
  parameter int DEVSEL_TO = 5,
  parameter int LAT_TIMER = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  pci_initiator_ctrl_if.master        bus,
  input  logic                        start,
  input  logic [3:0]                  nwords,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  status,
  output logic [3:0]                  words_left
);
  typedef enum logic [2:0] {IDLE, REQ_BUS, ADDR, DATA, LAST, TURN} state_t;
  // thresholds are compared against the pre-increment count, so the limit is hit in that same cycle
  localparam logic [2:0] DTO = 3'(DEVSEL_TO - 1);
  localparam logic [4:0] LTO = 5'(LAT_TIMER - 1);
  state_t     r_state, w_nstate;
  logic [2:0] r_dcnt;
  logic [4:0] r_lcnt;
  logic       r_seen, r_force, w_nforce;
  logic       r_req, r_frame, r_irdy, r_oe, r_ap, r_busy, r_done;
  logic [1:0] r_status, w_nstatus;
  logic [3:0] r_wl, w_nwl;
  logic       w_data, w_xfer, w_final, w_disc, w_tabort, w_mabort, w_lat;
  assign w_data   = r_state == DATA;
  assign w_xfer   = w_data && !bus.TRDY && !bus.DEVSEL;
  assign w_final  = r_wl <= 4'd1 || r_force;
  assign w_disc   = !bus.STOP && !bus.DEVSEL;
  assign w_tabort = !bus.STOP && bus.DEVSEL && r_seen;
  assign w_mabort = bus.DEVSEL && !r_seen && r_dcnt >= DTO;
  assign w_lat    = r_lcnt >= LTO && bus.GNT && r_wl > 4'd1;
  always_comb begin
    w_nstate  = r_state;
    w_nwl     = r_wl;
    w_nstatus = r_status;
    w_nforce  = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_nstate  = REQ_BUS;
        w_nwl     = nwords == 4'd0 ? 4'd1 : nwords;
        w_nstatus = 2'b00;
      end
      REQ_BUS: if (!bus.GNT && bus.FRAME_in && bus.IRDY_in) w_nstate = ADDR;
      ADDR: w_nstate = DATA;
      DATA: begin
        w_nwl    = r_wl - {3'd0, w_xfer};
        w_nforce = r_force || w_lat;
        if (w_mabort || w_tabort || w_disc) begin
          w_nstatus = w_mabort ? 2'b01 : w_tabort ? 2'b10 : 2'b11;
          w_nstate  = w_final ? TURN : LAST;
        end else if (w_xfer && w_final) begin
          w_nstatus = w_nwl != 4'd0 ? 2'b11 : 2'b00;
          w_nstate  = TURN;
        end
      end
      LAST: w_nstate = TURN;
      default: w_nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wl     <= 4'd0;
      r_status <= 2'b00;
      r_dcnt   <= 3'd0;
      r_lcnt   <= 5'd0;
      r_seen   <= 1'b0;
      r_force  <= 1'b0;
      r_req    <= 1'b1;
      r_frame  <= 1'b1;
      r_irdy   <= 1'b1;
      r_oe     <= 1'b0;
      r_ap     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_wl     <= w_nwl;
      r_status <= w_nstatus;
      r_force  <= w_nforce;
      r_dcnt   <= w_data ? r_dcnt + {2'd0, r_dcnt != 3'b111} : 3'd0;
      r_lcnt   <= w_data ? r_lcnt + {4'd0, r_lcnt != 5'b11111} : 5'd0;
      r_seen   <= w_data && (r_seen || !bus.DEVSEL);
      r_req    <= w_nstate != REQ_BUS;
      r_frame  <= !(w_nstate == ADDR || (w_nstate == DATA && w_nwl > 4'd1 && !w_nforce));
      r_irdy   <= !(w_nstate == DATA || w_nstate == LAST);
      r_oe     <= w_nstate inside {ADDR, DATA, LAST, TURN};
      r_ap     <= w_nstate == ADDR;
      r_busy   <= w_nstate != IDLE;
      r_done   <= w_nstate == TURN;
    end
  end
  assign bus.REQ        = r_req;
  assign bus.FRAME      = r_frame;
  assign bus.IRDY       = r_irdy;
  assign bus.ad_oe      = r_oe;
  assign bus.addr_phase = r_ap;
  assign bus.xfer       = w_xfer;
  assign busy           = r_busy;
  assign done           = r_done;
  assign status         = r_status;
  assign words_left     = r_wl;
endmodule
